// File: rtl/enc_bcd_counter.sv
// Encoder-detent to packed-BCD up/down counter with per-direction pulse prescalers.
// Zero latency: count and step pulse update on the edge sampling the final pulse; no backpressure.
module enc_bcd_counter #(
  parameter int DIGITS          = 2,
  parameter int PULSES_PER_STEP = 4,
  parameter int MIN_VALUE       = 0,
  parameter int MAX_VALUE       = 99,
  parameter int INIT_VALUE      = 0,
  parameter int WRAP            = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cw,
  input  logic                  ccw,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd_count,
  output logic                  step_up,
  output logic                  step_down,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int W  = 4 * DIGITS;
  localparam int AW = $clog2(PULSES_PER_STEP + 1);

  typedef logic [W-1:0] bcd_t;

  function automatic bcd_t to_bcd(input int v);
    bcd_t r;
    int   x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c && v[4*i +: 4] == 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] + {3'b000, c};
        c = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b && v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - {3'b000, b};
        b = 1'b0;
      end
    end
    return r;
  endfunction

  localparam bcd_t           MIN_BCD  = to_bcd(MIN_VALUE);
  localparam bcd_t           MAX_BCD  = to_bcd(MAX_VALUE);
  localparam bcd_t           INIT_BCD = to_bcd(INIT_VALUE);
  localparam logic [AW-1:0]  ACC_LAST = AW'(PULSES_PER_STEP - 1);

  generate
    if (MIN_VALUE >= MAX_VALUE || MAX_VALUE >= 10**DIGITS ||
        INIT_VALUE < MIN_VALUE || INIT_VALUE > MAX_VALUE || PULSES_PER_STEP == 0) begin : g_bad_params
      $error("enc_bcd_counter: illegal parameter combination");
    end
  endgenerate

  bcd_t          count_q, count_d;
  logic [AW-1:0] cw_acc_q, cw_acc_d;
  logic [AW-1:0] ccw_acc_q, ccw_acc_d;
  logic          step_up_q, step_up_d;
  logic          step_down_q, step_down_d;
  logic          up_req, dn_req;

  always_comb begin
    count_d     = count_q;
    cw_acc_d    = cw_acc_q;
    ccw_acc_d   = ccw_acc_q;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    up_req      = 1'b0;
    dn_req      = 1'b0;

    // Simultaneous cw and ccw is noise: nothing moves.
    if (cw && !ccw) begin
      ccw_acc_d = '0;
      if (cw_acc_q == ACC_LAST) begin
        cw_acc_d = '0;
        up_req   = 1'b1;
      end else begin
        cw_acc_d = cw_acc_q + AW'(1);
      end
    end else if (ccw && !cw) begin
      cw_acc_d = '0;
      if (ccw_acc_q == ACC_LAST) begin
        ccw_acc_d = '0;
        dn_req    = 1'b1;
      end else begin
        ccw_acc_d = ccw_acc_q + AW'(1);
      end
    end

    if (up_req) begin
      if (count_q != MAX_BCD) begin
        count_d   = bcd_inc(count_q);
        step_up_d = 1'b1;
      end else if (WRAP != 0) begin
        count_d   = MIN_BCD;
        step_up_d = 1'b1;
      end
    end else if (dn_req) begin
      if (count_q != MIN_BCD) begin
        count_d     = bcd_dec(count_q);
        step_down_d = 1'b1;
      end else if (WRAP != 0) begin
        count_d     = MAX_BCD;
        step_down_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q     <= INIT_BCD;
      cw_acc_q    <= '0;
      ccw_acc_q   <= '0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      cw_acc_q    <= cw_acc_d;
      ccw_acc_q   <= ccw_acc_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
    end
  end

  assign bcd_count = count_q;
  assign step_up   = step_up_q;
  assign step_down = step_down_q;
  assign at_max    = (count_q == MAX_BCD);
  assign at_min    = (count_q == MIN_BCD);

endmodule

// File: tb/tb_enc_bcd_counter.sv
// Bench for enc_bcd_counter: three parameterisations driven one at a time, scoreboarded against a decimal model.
module tb_enc_bcd_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst = '0, clr = '0, cw = '0, ccw = '0;
  logic [7:0]  cnt0, cnt1;
  logic [11:0] cnt2;
  logic [2:0]  up, dn, mx, mn;

  enc_bcd_counter u0 (
    .clk(clk), .reset(rst[0]), .cw(cw[0]), .ccw(ccw[0]), .clear(clr[0]),
    .bcd_count(cnt0), .step_up(up[0]), .step_down(dn[0]), .at_max(mx[0]), .at_min(mn[0]));

  enc_bcd_counter #(.WRAP(1)) u1 (
    .clk(clk), .reset(rst[1]), .cw(cw[1]), .ccw(ccw[1]), .clear(clr[1]),
    .bcd_count(cnt1), .step_up(up[1]), .step_down(dn[1]), .at_max(mx[1]), .at_min(mn[1]));

  enc_bcd_counter #(.DIGITS(3), .PULSES_PER_STEP(2), .MAX_VALUE(250), .INIT_VALUE(199)) u2 (
    .clk(clk), .reset(rst[2]), .cw(cw[2]), .ccw(ccw[2]), .clear(clr[2]),
    .bcd_count(cnt2), .step_up(up[2]), .step_down(dn[2]), .at_max(mx[2]), .at_min(mn[2]));

  // Per-instance parameters and decimal model state.
  int P_PPS [3] = '{4, 4, 2};
  int P_MIN [3] = '{0, 0, 0};
  int P_MAX [3] = '{99, 99, 250};
  int P_INIT[3] = '{0, 0, 199};
  int P_WRAP[3] = '{0, 1, 0};
  int m_val[3], m_cwa[3], m_ccwa[3];

  typedef struct {
    string       tag;
    int          id;
    logic [15:0] v;   // {step_up, step_down, at_max, at_min, count[11:0]}
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [11:0] cnt_of(input int id);
    case (id)
      0:       return {4'h0, cnt0};
      1:       return {4'h0, cnt1};
      default: return cnt2;
    endcase
  endfunction

  function automatic logic [15:0] obs(input int id);
    return {up[id], dn[id], mx[id], mn[id], cnt_of(id)};
  endfunction

  task automatic model_step(input int id, input bit c, input bit cc, input bit cl, input bit rs,
                            input string tag, output exp_t e);
    bit u = 1'b0;
    bit d = 1'b0;
    if (rs || cl) begin
      m_val[id] = P_INIT[id]; m_cwa[id] = 0; m_ccwa[id] = 0;
    end else if (c && !cc) begin
      m_ccwa[id] = 0;
      m_cwa[id]++;
      if (m_cwa[id] == P_PPS[id]) begin
        m_cwa[id] = 0;
        if (m_val[id] < P_MAX[id]) begin m_val[id]++; u = 1'b1; end
        else if (P_WRAP[id] != 0) begin m_val[id] = P_MIN[id]; u = 1'b1; end
      end
    end else if (cc && !c) begin
      m_cwa[id] = 0;
      m_ccwa[id]++;
      if (m_ccwa[id] == P_PPS[id]) begin
        m_ccwa[id] = 0;
        if (m_val[id] > P_MIN[id]) begin m_val[id]--; d = 1'b1; end
        else if (P_WRAP[id] != 0) begin m_val[id] = P_MAX[id]; d = 1'b1; end
      end
    end
    e.tag = tag;
    e.id  = id;
    e.v   = {u, d, m_val[id] == P_MAX[id], m_val[id] == P_MIN[id], to_bcd(m_val[id])};
  endtask

  task automatic compare_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.id), e.v);
    end
  endtask

  task automatic cycle(input int id, input bit c, input bit cc, input bit cl, input bit rs, input string tag);
    exp_t e;
    @(negedge clk);
    cw[id] = c; ccw[id] = cc; clr[id] = cl; rst[id] = rs;
    model_step(id, c, cc, cl, rs, tag, e);
    sb.push_back(e);
    @(posedge clk); #1;
    cw = '0; ccw = '0; clr = '0; rst = '0;
    compare_all();
  endtask

  task automatic reset_all();
    exp_t e;
    @(negedge clk);
    rst = 3'b111;
    for (int i = 0; i < 3; i++) begin
      model_step(i, 1'b0, 1'b0, 1'b0, 1'b1, "reset", e);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    rst = '0;
    compare_all();
  endtask

  task automatic pulses(input int id, input int n, input bit c, input bit cc, input string tag);
    for (int i = 0; i < n; i++) cycle(id, c, cc, 1'b0, 1'b0, tag);
  endtask

  task automatic expect_cnt(input string tag, input int id, input logic [11:0] exp);
    check(tag, {4'h0, cnt_of(id)}, {4'h0, exp});
  endtask

  initial begin
    reset_all();
    check("reset_flags0", {12'h000, mx[0], mn[0], up[0], dn[0]}, 16'h0004);
    expect_cnt("reset_cnt2", 2, 12'h199);

    // Isolated pulses: no change until the fourth.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0, "iso_cw");
      cycle(0, 0, 0, 0, 0, "iso_idle");
    end
    expect_cnt("iso_pulse3", 0, 12'h000);
    cycle(0, 1, 0, 0, 0, "iso_cw4");
    expect_cnt("iso_pulse4", 0, 12'h001);
    cycle(0, 0, 0, 0, 0, "iso_after");

    pulses(0, 4, 0, 1, "dn_to_0");
    pulses(0, 4, 0, 1, "sat_min");
    expect_cnt("sat_min_cnt", 0, 12'h000);

    // Direction change discards a partial accumulation.
    pulses(0, 3, 1, 0, "dir_cw3");
    pulses(0, 1, 0, 1, "dir_ccw1");
    pulses(0, 3, 1, 0, "dir_cw3b");
    expect_cnt("dir_nochg", 0, 12'h000);
    pulses(0, 1, 1, 0, "dir_cw4");
    expect_cnt("dir_step", 0, 12'h001);

    // Noise then clean steps from a cleared count.
    cycle(0, 0, 0, 1, 0, "clear");
    pulses(0, 10, 1, 1, "noise");
    expect_cnt("noise_cnt", 0, 12'h000);
    pulses(0, 4, 1, 0, "post_noise");
    expect_cnt("post_noise_cnt", 0, 12'h001);

    pulses(0, 32, 1, 0, "to_09");
    expect_cnt("at_09", 0, 12'h009);
    pulses(0, 4, 1, 0, "carry");
    expect_cnt("carry_10", 0, 12'h010);
    pulses(0, 4, 0, 1, "borrow");
    expect_cnt("borrow_09", 0, 12'h009);

    pulses(0, 360, 1, 0, "to_99");
    expect_cnt("at_99", 0, 12'h099);
    pulses(0, 4, 1, 0, "sat_max");
    expect_cnt("sat_max_cnt", 0, 12'h099);

    // Clear mid-accumulation.
    pulses(0, 2, 1, 0, "pre_clr");
    cycle(0, 0, 0, 1, 0, "mid_clear");
    pulses(0, 3, 1, 0, "post_clr3");
    expect_cnt("post_clr3_cnt", 0, 12'h000);
    pulses(0, 1, 1, 0, "post_clr4");
    expect_cnt("post_clr4_cnt", 0, 12'h001);

    // Wrapping instance.
    pulses(1, 4, 0, 1, "wrap_dn");
    expect_cnt("wrap_dn_cnt", 1, 12'h099);
    pulses(1, 4, 1, 0, "wrap_up");
    expect_cnt("wrap_up_cnt", 1, 12'h000);
    pulses(1, 4, 0, 1, "wrap_dn2");
    expect_cnt("wrap_dn2_cnt", 1, 12'h099);

    // Three-digit instance with two pulses per step.
    pulses(2, 2, 1, 0, "d3_up");
    expect_cnt("d3_200", 2, 12'h200);
    cycle(2, 0, 0, 0, 1, "d3_reset");
    pulses(2, 1, 1, 0, "d3_half");
    cycle(2, 0, 0, 0, 1, "d3_mid_reset");
    expect_cnt("d3_reset_cnt", 2, 12'h199);
    pulses(2, 1, 1, 0, "d3_one");
    expect_cnt("d3_one_cnt", 2, 12'h199);
    pulses(2, 1, 1, 0, "d3_two");
    expect_cnt("d3_two_cnt", 2, 12'h200);
    pulses(2, 4, 0, 1, "d3_dn");
    expect_cnt("d3_dn_cnt", 2, 12'h198);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/enc_bcd_counter.md
Name: enc_bcd_counter

Overview:
Parametrised quadrature-step-to-BCD up/down counter. It sits downstream of the encoder direction decoder, which supplies one-cycle cw/ccw pulses, and upstream of the 7-segment display driver. It accumulates PULSES_PER_STEP pulses per detent. It keeps a DIGITS-wide packed-BCD count between MIN_VALUE and MAX_VALUE, and either saturates or wraps at the limits.

Parameters:
DIGITS, 2, number of BCD digits; bcd_count width is 4*DIGITS
PULSES_PER_STEP, 4, encoder pulses per count step (1..15)
MIN_VALUE, 0, lowest count (decimal integer)
MAX_VALUE, 99, highest count (decimal integer); MIN_VALUE < MAX_VALUE <= 10^DIGITS-1
INIT_VALUE, 0, count loaded on reset or clear; MIN_VALUE <= INIT_VALUE <= MAX_VALUE
WRAP, 0, 0 = saturate at limits, 1 = wrap MAX<->MIN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cw  in  1  one-cycle clockwise pulse
ccw  in  1  one-cycle counter-clockwise pulse
clear  in  1  synchronous load of INIT_VALUE; clears both prescalers
bcd_count  out  4*DIGITS  packed BCD count; digit 0 in [3:0]
step_up  out  1  one-cycle pulse when the count incremented or wrapped up
step_down  out  1  one-cycle pulse when the count decremented or wrapped down
at_max  out  1  bcd_count == MAX_VALUE
at_min  out  1  bcd_count == MIN_VALUE

Behaviour:
- One clock, clk. reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: bcd_count = BCD(INIT_VALUE), cw_acc = ccw_acc = 0, step_up = step_down = 0. at_max and at_min are decoded from the reset count.
- Priority, highest first: reset > clear > pulse processing. clear has the same effect as reset on count and prescalers, and step_up/step_down are 0 in that cycle.
- Prescalers: cw_acc and ccw_acc, each $clog2(PULSES_PER_STEP+1) bits.
- cw=1, ccw=0:
  - if cw_acc == PULSES_PER_STEP-1: cw_acc <= 0 and an up-step is requested;
  - else cw_acc <= cw_acc+1.
  - In both cases ccw_acc <= 0 (a direction change discards the partial opposite accumulation).
- ccw=1, cw=0: symmetric; the cw_acc counter is cleared.
- cw=1 and ccw=1 in the same cycle: treated as noise. Both prescalers and the count are unchanged; no step pulse.
- Latency: on the clock edge that samples the PULSES_PER_STEP-th pulse, bcd_count takes its new value and step_up/step_down rises for exactly one cycle. There is no extra pipeline stage.
- Up-step:
  - count < MAX: BCD increment.
  - count == MAX and WRAP=1: count <= MIN, step_up=1.
  - count == MAX and WRAP=0: count holds, step_up=0. The prescaler is still cleared, so the pulses are consumed.
- Down-step: symmetric, using MIN and step_down.
- BCD arithmetic, increment: digit-serial ripple. Digit i becomes 0 with carry out if it is 9 and carry in is 1; otherwise digit + carry in. Carry into digit 0 is 1.
- BCD arithmetic, decrement: digit i becomes 9 with borrow out if it is 0 and borrow in is 1; otherwise digit - borrow in.
- Non-BCD nibbles (A-F) never appear in bcd_count. Limit comparisons use the BCD encodings of MIN_VALUE and MAX_VALUE, computed at elaboration.
- at_max and at_min are combinational from the registered bcd_count.
- Reset or clear during a partial accumulation discards it. The next step then needs a full PULSES_PER_STEP pulses.
- Elaboration check: $error if MIN_VALUE >= MAX_VALUE, MAX_VALUE >= 10**DIGITS, INIT_VALUE is out of range, or PULSES_PER_STEP is 0.

Test Plan:
- Defaults, after reset: 4 isolated cw pulses -> bcd_count stays 8'h00 through pulse 3, becomes 8'h01 on the edge sampling pulse 4, step_up high for that one cycle; at_min was 1 before the step and 0 after.
- Count 8'h09, 4 cw pulses -> 8'h10. Count 8'h10, 4 ccw pulses -> 8'h09. Count 8'h00 with MIN_VALUE=0 and WRAP=0, 4 ccw pulses -> holds 8'h00, no step_down, at_min stays 1.
- 3 cw, then 1 ccw, then 3 cw -> no change. A 4th cw -> 8'h01. Confirms the direction change cleared cw_acc.
- Count 8'h99, WRAP=0: 4 cw -> holds 8'h99, at_max=1, step_up=0. Rerun with WRAP=1: 4 cw -> 8'h00 with step_up pulse; 4 ccw -> 8'h99 with step_down pulse.
- cw and ccw asserted together for 10 cycles -> no count or prescaler change. Then 4 cw -> 8'h01.
- DIGITS=3, MAX_VALUE=250, INIT_VALUE=199, PULSES_PER_STEP=2: 2 cw -> 12'h200. Assert reset mid-accumulation (after 1 cw) -> 12'h199. The next 2 cw are required for 12'h200.
